exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width; legal values are 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), SHALL set the width of the shift amount.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 Port in_valid  input  1  SHALL flag a valid operation on the inputs.
REQ-006 Port in_ready  output  1  SHALL flag that the block can accept an operation.
REQ-007 Ports DataA, DataB, PC, Imm  input  XLEN  SHALL carry rs1, rs2, PC and the immediate.
REQ-008 Ports ASel, BSel, BrUn  input  1  SHALL select PC/DataA, Imm/DataB and unsigned branch compare.
REQ-009 Port inst  input  32  SHALL carry the instruction word.
REQ-010 Port out_valid  output  1  SHALL flag a valid result.
REQ-011 Port out_ready  input  1  SHALL flag that the consumer takes the result.
REQ-012 Port alu  output  XLEN  SHALL carry the result.
REQ-013 Ports BrEq, BrLT  output  1  SHALL carry the branch compare of DataA against DataB.
REQ-014 Port busy  output  1  SHALL be high while a multi-cycle operation is iterating.

Function
REQ-015 An accept SHALL occur on a rising edge when in_valid and in_ready are both 1; the block SHALL capture all inputs at that edge.
REQ-016 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-017 muxA SHALL be PC when ASel=1, otherwise DataA; muxB SHALL be Imm when BSel=1, otherwise DataB.
REQ-018 Opcode 0110011 with funct7 0000000/0100000 SHALL implement ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND.
REQ-019 Opcode 0010011 SHALL implement ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI; SRAI is selected by inst[30].
REQ-020 Shift amounts SHALL be muxB[SHW-1:0].
REQ-021 Opcodes 0000011, 0100011, 1100011, 1101111, 1100111, 0010111 SHALL produce muxA+muxB; opcode 0110111 SHALL produce muxB.
REQ-022 Opcode 0110011 with funct7 0000001 SHALL implement MUL (low XLEN bits), DIV, DIVU, REM and REMU as multi-cycle operations; MULH* SHALL return 0.
REQ-023 An unsupported opcode or funct SHALL produce alu=0, with BrEq and BrLT still valid.
REQ-024 BrEq SHALL be (DataA==DataB); BrLT SHALL be the unsigned compare when BrUn=1 and the full two's-complement signed compare when BrUn=0.
REQ-025 Single-cycle ops SHALL assert out_valid on the edge following accept, with alu, BrEq and BrLT registered.
REQ-026 The FSM SHALL have states IDLE, MUL, DIV and DONE:
  - IDLE to MUL or DIV on accept of an M-op;
  - MUL/DIV to DONE when the iteration counter reaches XLEN-1;
  - DONE to IDLE on the next edge, loading the output register.
REQ-027 Multi-cycle latency SHALL be fixed at XLEN+2 edges from accept to out_valid, independent of operand values.
REQ-028 MUL SHALL use shift-add, one bit per cycle; DIV/REM SHALL use restoring division on magnitudes with sign fix-up (quotient sign = sA^sB, remainder sign = sA).
REQ-029 Divide by zero SHALL give quotient all-ones and remainder = dividend.
REQ-030 Signed overflow (most-negative / -1) SHALL give quotient = dividend and remainder 0.
REQ-031 While out_valid=1 and out_ready=0, alu, BrEq, BrLT and out_valid SHALL hold stable.
REQ-032 A result accepted by the consumer in the same cycle as a new accept SHALL be replaced by the new single-cycle result with no bubble.

Reset
REQ-033 With rst_n=0: state=IDLE, counter=0, out_valid=0, alu=0, BrEq=0, BrLT=0, busy=0; in_ready SHALL be 0 while rst_n=0.
REQ-034 Reset during iteration SHALL abort the operation; no result is produced.

Structure
REQ-035 Package exec_pkg SHALL hold the opcode/funct constants, the FSM state enum and the ALU op enum.
REQ-036 The iterative multiply/divide datapath SHALL be a sub-module named iter_muldiv.

Verification
REQ-037 ADD with DataA=5, DataB=7, BSel=0 -> alu=12 one edge after accept.
REQ-038 BLT with DataA=0xFFFFFFFF, DataB=1: BrUn=0 -> BrLT=1; BrUn=1 -> BrLT=0.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> alu=0x80000000 after 34 edges, busy high during iteration.
REQ-040 DIVU x/0 -> 0xFFFFFFFF; REM -7/2 -> alu=0xFFFFFFFF.
REQ-041 Hold out_ready=0 for 5 cycles after MUL 3*-4 -> alu stays 0xFFFFFFF4 and in_ready=0.
REQ-042 Assert rst_n=0 mid-DIV -> out_valid=0; the next ADD completes correctly.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants and types for the execute unit: opcode/funct encodings,
// FSM state and ALU operation enums, and the instruction decoder.
package exec_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_MUL  = 3'd0;
    localparam logic [2:0] F3_DIV  = 3'd4;
    localparam logic [2:0] F3_DIVU = 3'd5;
    localparam logic [2:0] F3_REM  = 3'd6;
    localparam logic [2:0] F3_REMU = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB,
        ALU_ZERO,
        ALU_MUL,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_t;

    function automatic logic is_muldiv(input alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // MULH* and anything unrecognised fall through to ALU_ZERO.
    function automatic alu_op_t decode_op(input logic [6:0] opcode,
                                          input logic [2:0] f3,
                                          input logic [6:0] f7);
        alu_op_t op;
        op = ALU_ZERO;
        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  op = ALU_ADD;
                        F3_SLL:  op = ALU_SLL;
                        F3_SLT:  op = ALU_SLT;
                        F3_SLTU: op = ALU_SLTU;
                        F3_XOR:  op = ALU_XOR;
                        F3_SR:   op = ALU_SRL;
                        F3_OR:   op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == F3_ADD)
                        op = ALU_SUB;
                    else if (f3 == F3_SR)
                        op = ALU_SRA;
                end else if (f7 == F7_MULDIV) begin
                    case (f3)
                        F3_MUL:  op = ALU_MUL;
                        F3_DIV:  op = ALU_DIV;
                        F3_DIVU: op = ALU_DIVU;
                        F3_REM:  op = ALU_REM;
                        F3_REMU: op = ALU_REMU;
                        default: op = ALU_ZERO;
                    endcase
                end
            end
            OPC_OPIMM: begin
                case (f3)
                    F3_ADD:  op = ALU_ADD;
                    F3_SLL:  op = ALU_SLL;
                    F3_SLT:  op = ALU_SLT;
                    F3_SLTU: op = ALU_SLTU;
                    F3_XOR:  op = ALU_XOR;
                    F3_SR:   op = f7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_AUIPC:
                op = ALU_ADD;
            OPC_LUI:
                op = ALU_PASSB;
            default:
                op = ALU_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_unit_iter_muldiv.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide
// step per cycle while step is high. The controller owns the step count;
// after XLEN steps result holds the final, sign-corrected value.
module iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic            want_rem,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    // acc: product accumulator (mul) or partial remainder (div)
    // opa: multiplicand (mul) or dividend shifting out / quotient shifting in (div)
    // opb: multiplier (mul) or divisor magnitude (div)
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] dividend;
    logic            div_mode;
    logic            rem_mode;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;

    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   div_trial;
    logic [XLEN:0]   div_diff;
    logic            div_bit;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign sign_a = is_signed & a[XLEN-1];
    assign sign_b = is_signed & b[XLEN-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    assign div_trial = {acc[XLEN-1:0], opa[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, opb};
    assign div_bit   = (div_trial >= {1'b0, opb});

    // Operand load on start, otherwise one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            dividend <= '0;
            div_mode <= 1'b0;
            rem_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            dividend <= a;
            div_mode <= is_div;
            rem_mode <= want_rem;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= is_div && (b == '0);
            opa      <= is_div ? mag_a : a;
            opb      <= is_div ? mag_b : b;
        end else if (step) begin
            if (div_mode) begin
                acc <= div_bit ? div_diff : div_trial;
                opa <= {opa[XLEN-2:0], div_bit};
            end else begin
                if (opb[0])
                    acc <= acc + {1'b0, opa};
                opa <= opa << 1;
                opb <= opb >> 1;
            end
        end
    end

    assign q_fix = neg_q ? -opa : opa;
    assign r_fix = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];

    // Final selection; divide-by-zero bypasses the sign fix-up
    always_comb begin
        result = acc[XLEN-1:0];
        if (div_mode) begin
            if (div_zero)
                result = rem_mode ? dividend : '1;
            else
                result = rem_mode ? r_fix : q_fix;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute unit: single-cycle RV ALU plus iterative M-extension ops,
// with a valid/ready handshake on both sides and a registered result.
//
// state   | meaning
// IDLE    | ready for a new operation (subject to output back-pressure)
// MUL     | shift-add multiply iterating, one bit per cycle
// DIV     | restoring divide iterating, one bit per cycle
// DONE    | iteration finished; result loads into the output register
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] DataA,
    input  logic [XLEN-1:0] DataB,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Imm,
    input  logic            ASel,
    input  logic            BSel,
    input  logic            BrUn,
    input  logic [31:0]     inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu,
    output logic            BrEq,
    output logic            BrLT,
    output logic            busy
);

    state_t          state;
    state_t          state_nx;
    logic [SHW-1:0]  cnt;
    alu_op_t         op;
    logic            is_mop;
    logic            accept;
    logic [XLEN-1:0] mux_a;
    logic [XLEN-1:0] mux_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_c;
    logic            br_eq_c;
    logic            br_lt_c;
    logic            br_eq_m;
    logic            br_lt_m;
    logic            md_start;
    logic            md_step;
    logic [XLEN-1:0] md_result;
    logic            unused_inst;

    // rd and rs fields are resolved outside this block
    assign unused_inst = ^{inst[24:15], inst[11:7]};

    assign op     = decode_op(inst[6:0], inst[14:12], inst[31:25]);
    assign is_mop = is_muldiv(op);
    assign accept = in_valid && in_ready;

    assign mux_a = ASel ? PC  : DataA;
    assign mux_b = BSel ? Imm : DataB;
    assign shamt = mux_b[SHW-1:0];

    assign br_eq_c = (DataA == DataB);
    assign br_lt_c = BrUn ? (DataA < DataB) : ($signed(DataA) < $signed(DataB));

    // Single-cycle ALU result
    always_comb begin
        alu_c = '0;
        case (op)
            ALU_ADD:   alu_c = mux_a + mux_b;
            ALU_SUB:   alu_c = mux_a - mux_b;
            ALU_SLL:   alu_c = mux_a << shamt;
            ALU_SLT:   alu_c = {{(XLEN-1){1'b0}}, ($signed(mux_a) < $signed(mux_b))};
            ALU_SLTU:  alu_c = {{(XLEN-1){1'b0}}, (mux_a < mux_b)};
            ALU_XOR:   alu_c = mux_a ^ mux_b;
            ALU_SRL:   alu_c = mux_a >> shamt;
            ALU_SRA:   alu_c = $signed(mux_a) >>> shamt;
            ALU_OR:    alu_c = mux_a | mux_b;
            ALU_AND:   alu_c = mux_a & mux_b;
            ALU_PASSB: alu_c = mux_b;
            default:   alu_c = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mop)
                    state_nx = (op == ALU_MUL) ? ST_MUL : ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (cnt == SHW'(XLEN-1))
                    state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready is forced low while reset is asserted
    always_comb begin
        busy     = (state == ST_MUL) || (state == ST_DIV);
        in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
    end

    assign md_start = accept && is_mop;
    assign md_step  = busy;

    // Iteration counter, cleared whenever not iterating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (busy)
            cnt <= cnt + SHW'(1);
        else
            cnt <= '0;
    end

    // Branch flags of an M-op are taken at accept and released with its result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_eq_m <= 1'b0;
            br_lt_m <= 1'b0;
        end else if (accept) begin
            br_eq_m <= br_eq_c;
            br_lt_m <= br_lt_c;
        end
    end

    // Output register: a new single-cycle result overwrites a consumed one
    // in the same edge, so back-to-back ops have no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu       <= '0;
            BrEq      <= 1'b0;
            BrLT      <= 1'b0;
        end else if (accept && !is_mop) begin
            out_valid <= 1'b1;
            alu       <= alu_c;
            BrEq      <= br_eq_c;
            BrLT      <= br_lt_c;
        end else if (state == ST_DONE) begin
            out_valid <= 1'b1;
            alu       <= md_result;
            BrEq      <= br_eq_m;
            BrLT      <= br_lt_m;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    iter_muldiv #(
        .XLEN(XLEN)
    ) u_iter_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .step      (md_step),
        .is_div    (op != ALU_MUL),
        .is_signed ((op == ALU_DIV) || (op == ALU_REM)),
        .want_rem  ((op == ALU_REM) || (op == ALU_REMU)),
        .a         (mux_a),
        .b         (mux_b),
        .result    (md_result)
    );

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit (XLEN=32).
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] DataA, DataB, PC, Imm;
    logic        ASel, BSel, BrUn;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu;
    logic        BrEq, BrLT;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        asel;
        logic        bsel;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .DataA(DataA), .DataB(DataB), .PC(PC), .Imm(Imm),
        .ASel(ASel), .BSel(BSel), .BrUn(BrUn), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .alu(alu),
        .BrEq(BrEq), .BrLT(BrLT), .busy(busy)
    );

    function automatic logic [31:0] r_inst(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_inst(input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd2, f3, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] o_inst(input logic [6:0] opc);
        return {25'd0, opc};
    endfunction

    task automatic set_op(input logic [31:0] i_w, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic asel, input logic bsel, input logic brun);
        inst = i_w; DataA = a; DataB = b; PC = pc; Imm = imm;
        ASel = asel; BSel = bsel; BrUn = brun;
    endtask

    // Present one op for a single edge; returns 1ns after that edge
    task automatic issue(input logic [31:0] i_w, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic asel, input logic bsel, input logic brun);
        set_op(i_w, a, b, pc, imm, asel, bsel, brun);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted after the accept edge until out_valid, bounded
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        set_op(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (alu !== 32'd0) begin errors++; $display("FAIL reset_alu got %h want 0", alu); end
        checks++; if (BrEq !== 1'b0 || BrLT !== 1'b0) begin errors++; $display("FAIL reset_br got %b%b want 00", BrEq, BrLT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset got in_ready=%b out_valid=%b want 1,0", in_ready, out_valid); end
    endtask

    task automatic test_alu();
        vec_t v[$];
        v.push_back('{r_inst(7'h00, 3'd0), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'd12});
        v.push_back('{r_inst(7'h20, 3'd0), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFE});
        v.push_back('{r_inst(7'h00, 3'd1), 32'd1, 32'd33, 32'd0, 32'd0, 1'b0, 1'b0, 32'd2});
        v.push_back('{r_inst(7'h00, 3'd2), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1});
        v.push_back('{r_inst(7'h00, 3'd3), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        v.push_back('{r_inst(7'h00, 3'd4), 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0FF00FF0});
        v.push_back('{r_inst(7'h00, 3'd5), 32'h80000000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'h08000000});
        v.push_back('{r_inst(7'h20, 3'd5), 32'h80000000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'hF8000000});
        v.push_back('{r_inst(7'h00, 3'd6), 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFF0F0});
        v.push_back('{r_inst(7'h00, 3'd7), 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 1'b0, 1'b0, 32'hF000F000});
        v.push_back('{i_inst(3'd0, 12'hFFF), 32'd10, 32'd99, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd9});
        v.push_back('{i_inst(3'd3, 12'hFFF), 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd1});
        v.push_back('{i_inst(3'd5, 12'h404), 32'hF0000000, 32'd0, 32'd0, 32'd4, 1'b0, 1'b1, 32'hFF000000});
        v.push_back('{i_inst(3'd5, 12'h004), 32'hF0000000, 32'd0, 32'd0, 32'd4, 1'b0, 1'b1, 32'h0F000000});
        v.push_back('{o_inst(7'b0110111), 32'd7, 32'd0, 32'd0, 32'h12345000, 1'b0, 1'b1, 32'h12345000});
        v.push_back('{o_inst(7'b0010111), 32'd7, 32'd0, 32'h1000, 32'h20, 1'b1, 1'b1, 32'h00001020});
        v.push_back('{o_inst(7'b0000011), 32'h100, 32'd0, 32'd0, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h000000FC});
        v.push_back('{r_inst(7'h01, 3'd1), 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        v.push_back('{r_inst(7'h20, 3'd1), 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        v.push_back('{o_inst(7'b1111111), 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        foreach (v[i]) begin
            issue(v[i].inst, v[i].a, v[i].b, v[i].pc, v[i].imm, v[i].asel, v[i].bsel, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || alu !== v[i].exp) begin
                errors++;
                $display("FAIL alu_vec[%0d] got valid=%b alu=%h want valid=1 alu=%h", i, out_valid, alu, v[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        issue(o_inst(7'b1100011), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (BrLT !== 1'b1 || BrEq !== 1'b0) begin errors++; $display("FAIL blt_signed got eq=%b lt=%b want 0,1", BrEq, BrLT); end
        issue(o_inst(7'b1100011), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (BrLT !== 1'b0 || BrEq !== 1'b0) begin errors++; $display("FAIL blt_unsigned got eq=%b lt=%b want 0,0", BrEq, BrLT); end
        issue(o_inst(7'b1100011), 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (BrLT !== 1'b0) begin errors++; $display("FAIL blt_extreme_signed got lt=%b want 0", BrLT); end
        issue(o_inst(7'b1100011), 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (BrLT !== 1'b1) begin errors++; $display("FAIL blt_extreme_unsigned got lt=%b want 1", BrLT); end
        issue(o_inst(7'b1111111), 32'h1234, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (alu !== 32'd0 || BrEq !== 1'b1 || BrLT !== 1'b0) begin errors++; $display("FAIL unsupported_br got alu=%h eq=%b lt=%b want 0,1,0", alu, BrEq, BrLT); end
    endtask

    task automatic test_div_overflow();
        issue(r_inst(7'h01, 3'd4), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL div_start got busy=%b valid=%b want 1,0", busy, out_valid); end
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k == 16) begin
                checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL div_mid got busy=%b in_ready=%b want 1,0", busy, in_ready); end
            end
            if (k == 32) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL div_early got valid=%b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1 || alu !== 32'h80000000) begin errors++; $display("FAIL div_overflow got valid=%b alu=%h want 1,80000000", out_valid, alu); end
        checks++; if (BrLT !== 1'b1 || BrEq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL div_flags got eq=%b lt=%b busy=%b want 0,1,0", BrEq, BrLT, busy); end
    endtask

    task automatic test_muldiv();
        vec_t v[$];
        int lat;
        v.push_back('{r_inst(7'h01, 3'd5), 32'd123, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF});
        v.push_back('{r_inst(7'h01, 3'd6), 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF});
        v.push_back('{r_inst(7'h01, 3'd4), 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFD});
        v.push_back('{r_inst(7'h01, 3'd6), 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1});
        v.push_back('{r_inst(7'h01, 3'd7), 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd7});
        v.push_back('{r_inst(7'h01, 3'd4), 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF});
        v.push_back('{r_inst(7'h01, 3'd6), 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFB});
        v.push_back('{r_inst(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        v.push_back('{r_inst(7'h01, 3'd5), 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'd14});
        v.push_back('{r_inst(7'h01, 3'd7), 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'd2});
        v.push_back('{r_inst(7'h01, 3'd0), 32'd123456, 32'd789, 32'd0, 32'd0, 1'b0, 1'b0, 32'd97406784});
        v.push_back('{r_inst(7'h01, 3'd0), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1});
        foreach (v[i]) begin
            issue(v[i].inst, v[i].a, v[i].b, v[i].pc, v[i].imm, v[i].asel, v[i].bsel, 1'b0);
            wait_result(lat);
            checks++;
            if (lat != 33 || alu !== v[i].exp) begin
                errors++;
                $display("FAIL muldiv_vec[%0d] got lat=%0d alu=%h want lat=33 alu=%h", i, lat, alu, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        int lat;
        out_ready = 1'b1;
        issue(r_inst(7'h01, 3'd0), 32'd3, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        wait_result(lat);
        checks++; if (lat != 33 || alu !== 32'hFFFFFFF4) begin errors++; $display("FAIL mul_result got lat=%0d alu=%h want 33,fffffff4", lat, alu); end
        set_op(r_inst(7'h00, 3'd0), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (alu !== 32'hFFFFFFF4 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got alu=%h valid=%b in_ready=%b want fffffff4,1,0", k, alu, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (alu !== 32'd12 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_release got alu=%h valid=%b want c,1", alu, out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_op(r_inst(7'h00, 3'd0), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (alu !== 32'd12 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got alu=%h valid=%b in_ready=%b want c,1,1", alu, out_valid, in_ready); end
        set_op(r_inst(7'h00, 3'd4), 32'd5, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (alu !== 32'd6 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got alu=%h valid=%b want 6,1", alu, out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        issue(r_inst(7'h01, 3'd4), 32'd100, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got valid=%b busy=%b in_ready=%b want 0,0,0", out_valid, busy, in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL aborted_result got %0d valid cycles want 0", seen); end
        issue(r_inst(7'h00, 3'd0), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (alu !== 32'd12 || out_valid !== 1'b1) begin errors++; $display("FAIL add_after_reset got alu=%h valid=%b want c,1", alu, out_valid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_div_overflow();
        test_muldiv();
        test_hold();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
